// File: rtl/neuron_update_scheduler_if.sv
// neuron_update_scheduler_if: tick/config inputs, engine handshake, spike FIFO readout and status
//   master : scheduler side (drives engine operands, spike head, status)
//   slave  : environment side (drives tick, config, engine results, spk_ready)
interface neuron_update_scheduler_if #(
  parameter int IDX_W = 2
);
  logic                    tick;
  logic                    cfg_we;
  logic [IDX_W-1:0]        cfg_idx;
  logic [3:0]              cfg_a;
  logic [3:0]              cfg_b;
  logic [7:0]              cfg_i;
  logic                    eng_start;
  logic signed [17:0]      eng_v;
  logic signed [17:0]      eng_u;
  logic [3:0]              eng_a;
  logic [3:0]              eng_b;
  logic [7:0]              eng_i;
  logic                    eng_done;
  logic signed [17:0]      eng_v_new;
  logic signed [17:0]      eng_u_new;
  logic                    eng_spike;
  logic                    spk_valid;
  logic [IDX_W-1:0]        spk_idx;
  logic                    spk_ready;
  logic                    busy;
  logic                    overrun;
  logic [7:0]              drop_cnt;
  modport master (
    input  tick, cfg_we, cfg_idx, cfg_a, cfg_b, cfg_i,
    input  eng_done, eng_v_new, eng_u_new, eng_spike, spk_ready,
    output eng_start, eng_v, eng_u, eng_a, eng_b, eng_i,
    output spk_valid, spk_idx, busy, overrun, drop_cnt
  );
  modport slave (
    output tick, cfg_we, cfg_idx, cfg_a, cfg_b, cfg_i,
    output eng_done, eng_v_new, eng_u_new, eng_spike, spk_ready,
    input  eng_start, eng_v, eng_u, eng_a, eng_b, eng_i,
    input  spk_valid, spk_idx, busy, overrun, drop_cnt
  );
endinterface

// File: rtl/neuron_update_scheduler.sv
// neuron_update_scheduler: time-multiplexes one Izhikevich update engine across N_NEURONS virtual neurons
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : tick/config in, engine operand/result handshake, spike event FIFO, busy/overrun/drop_cnt
module neuron_update_scheduler #(
  parameter int                 N_NEURONS  = 4,
  parameter int                 IDX_W      = 2,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic signed [17:0] V_INIT     = 18'sh3_4CCD,
  parameter logic signed [17:0] U_INIT     = 18'sh3_CCCD
) (
  input logic                        clk,
  input logic                        rst_n,
  neuron_update_scheduler_if.master  bus
);
  localparam int FA = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic signed [17:0] v_q [N_NEURONS];
  logic signed [17:0] v_d [N_NEURONS];
  logic signed [17:0] u_q [N_NEURONS];
  logic signed [17:0] u_d [N_NEURONS];
  logic [3:0]         a_q [N_NEURONS];
  logic [3:0]         a_d [N_NEURONS];
  logic [3:0]         b_q [N_NEURONS];
  logic [3:0]         b_d [N_NEURONS];
  logic [7:0]         i_q [N_NEURONS];
  logic [7:0]         i_d [N_NEURONS];
  logic signed [17:0] op_v_q, op_v_d, op_u_q, op_u_d;
  logic [3:0]         op_a_q, op_a_d, op_b_q, op_b_d;
  logic [7:0]         op_i_q, op_i_d;
  logic signed [17:0] vn_q, vn_d, un_q, un_d;
  logic               sp_q, sp_d;
  logic [IDX_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [IDX_W-1:0]   fifo_d [FIFO_DEPTH];
  logic [FA:0]        wp_q, wp_d, rp_q, rp_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         drop_q, drop_d;
  logic               load, last, push, pop, full, empty;
  assign last  = idx_q == IDX_W'(N_NEURONS - 1);
  assign push  = (state_q == WRITE) & sp_q;
  assign empty = wp_q == rp_q;
  // extra pointer bit distinguishes full from empty when the slot indices match
  assign full  = (wp_q ^ rp_q) == {1'b1, {FA{1'b0}}};
  assign pop   = ~empty & bus.spk_ready;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    v_d       = v_q;
    u_d       = u_q;
    a_d       = a_q;
    b_d       = b_q;
    i_d       = i_q;
    op_v_d    = op_v_q;
    op_u_d    = op_u_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_i_d    = op_i_q;
    vn_d      = vn_q;
    un_d      = un_q;
    sp_d      = sp_q;
    fifo_d    = fifo_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    drop_d    = drop_q;
    load      = 1'b0;
    overrun_d = overrun_q | (bus.tick & (state_q != IDLE));
    case (state_q)
      IDLE: if (bus.tick) begin
        state_d = ISSUE;
        idx_d   = '0;
        load    = 1'b1;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (bus.eng_done) begin
        state_d = WRITE;
        vn_d    = bus.eng_v_new;
        un_d    = bus.eng_u_new;
        sp_d    = bus.eng_spike;
      end
      WRITE: begin
        v_d[idx_q] = vn_q;
        u_d[idx_q] = un_q;
        state_d    = last ? IDLE : ISSUE;
        idx_d      = idx_q + 1'b1;
        load       = ~last;
      end
      default: state_d = IDLE;
    endcase
    // operands are latched on entry to ISSUE so later config writes cannot disturb an in-flight update
    if (load) begin
      op_v_d = v_q[idx_d];
      op_u_d = u_q[idx_d];
      op_a_d = a_q[idx_d];
      op_b_d = b_q[idx_d];
      op_i_d = i_q[idx_d];
    end
    if (bus.cfg_we) begin
      a_d[bus.cfg_idx] = bus.cfg_a;
      b_d[bus.cfg_idx] = bus.cfg_b;
      i_d[bus.cfg_idx] = bus.cfg_i;
    end
    if (push && (!full || pop)) begin
      fifo_d[wp_q[FA-1:0]] = idx_q;
      wp_d = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    if (push && full && !pop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      v_q       <= '{default: V_INIT};
      u_q       <= '{default: U_INIT};
      a_q       <= '{default: '0};
      b_q       <= '{default: '0};
      i_q       <= '{default: '0};
      op_v_q    <= '0;
      op_u_q    <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_i_q    <= '0;
      vn_q      <= '0;
      un_q      <= '0;
      sp_q      <= 1'b0;
      fifo_q    <= '{default: '0};
      wp_q      <= '0;
      rp_q      <= '0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      v_q       <= v_d;
      u_q       <= u_d;
      a_q       <= a_d;
      b_q       <= b_d;
      i_q       <= i_d;
      op_v_q    <= op_v_d;
      op_u_q    <= op_u_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_i_q    <= op_i_d;
      vn_q      <= vn_d;
      un_q      <= un_d;
      sp_q      <= sp_d;
      fifo_q    <= fifo_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end
  assign bus.eng_start = state_q == ISSUE;
  assign bus.eng_v     = op_v_q;
  assign bus.eng_u     = op_u_q;
  assign bus.eng_a     = op_a_q;
  assign bus.eng_b     = op_b_q;
  assign bus.eng_i     = op_i_q;
  assign bus.spk_valid = ~empty;
  assign bus.spk_idx   = empty ? '0 : fifo_q[rp_q[FA-1:0]];
  assign bus.busy      = state_q != IDLE;
  assign bus.overrun   = overrun_q;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_neuron_update_scheduler.sv
// tb_neuron_update_scheduler: randomized engine model plus per-timestep reference model of the scheduler
module tb_neuron_update_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int FD = 4;
  localparam logic signed [17:0] VI = 18'sh3_4CCD;
  localparam logic signed [17:0] UI = 18'sh3_CCCD;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  neuron_update_scheduler_if #(.IDX_W(IW)) bus ();
  neuron_update_scheduler #(.N_NEURONS(N), .IDX_W(IW), .FIFO_DEPTH(FD), .V_INIT(VI), .U_INIT(UI))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int calls = 0;
  int base = 0;
  int lat_min = 2;
  int lat_max = 2;
  int nstart = 0;
  int ek;
  int dv;
  logic [N-1:0] spk_mask = '0;
  logic signed [17:0] log_v [2048];
  logic signed [17:0] log_u [2048];
  logic [3:0]         log_a [2048];
  logic [3:0]         log_b [2048];
  logic [7:0]         log_i [2048];
  logic signed [17:0] res_v [2048];
  logic signed [17:0] res_u [2048];
  logic               res_s [2048];
  int                 lat_log [2048];
  logic signed [17:0] v_m [N];
  logic signed [17:0] u_m [N];
  logic [3:0]         a_m [N];
  logic [3:0]         b_m [N];
  logic [7:0]         i_m [N];
  logic signed [17:0] exp_v [N];
  logic signed [17:0] exp_u [N];
  logic [3:0]         exp_a [N];
  logic [3:0]         exp_b [N];
  logic [7:0]         exp_i [N];
  int exp_busy;
  int drop_m;
  int fifo_m [$];
  // engine: latches operands on eng_start, answers after lat cycles with a random v/u update
  initial begin
    bus.eng_done = 1'b0;
    bus.eng_v_new = '0;
    bus.eng_u_new = '0;
    bus.eng_spike = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.eng_start === 1'b1) begin
        ek = calls;
        calls++;
        log_v[ek] = bus.eng_v;
        log_u[ek] = bus.eng_u;
        log_a[ek] = bus.eng_a;
        log_b[ek] = bus.eng_b;
        log_i[ek] = bus.eng_i;
        dv = int'($urandom_range(0, 2000)) - 1000;
        res_v[ek] = bus.eng_v + 18'(dv);
        res_u[ek] = bus.eng_u ^ 18'($urandom);
        res_s[ek] = spk_mask[(ek - base) % N];
        lat_log[ek] = int'($urandom_range(lat_min, lat_max));
        repeat (lat_log[ek]) @(negedge clk);
        bus.eng_done = 1'b1;
        bus.eng_v_new = res_v[ek];
        bus.eng_u_new = res_u[ek];
        bus.eng_spike = res_s[ek];
        @(negedge clk);
        bus.eng_done = 1'b0;
        bus.eng_v_new = 18'($urandom);
        bus.eng_u_new = 18'($urandom);
        bus.eng_spike = 1'b1;
      end
    end
  end
  always @(negedge clk) if (bus.eng_start === 1'b1) nstart <= nstart + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1);
  end
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      v_m[k] = VI;
      u_m[k] = UI;
      a_m[k] = '0;
      b_m[k] = '0;
      i_m[k] = '0;
    end
    fifo_m.delete();
    drop_m = 0;
  endtask
  // one timestep: neuron k (k = 0..N-1) is sent its stored state and receives the engine result
  task automatic model_tick();
    exp_busy = 0;
    for (int k = 0; k < N; k++) begin
      exp_v[k] = v_m[k];
      exp_u[k] = u_m[k];
      exp_a[k] = a_m[k];
      exp_b[k] = b_m[k];
      exp_i[k] = i_m[k];
      v_m[k] = res_v[base + k];
      u_m[k] = res_u[base + k];
      exp_busy += lat_log[base + k] + 2;
      if (res_s[base + k]) begin
        if (fifo_m.size() < FD) fifo_m.push_back(k);
        else if (drop_m < 255) drop_m++;
      end
    end
  endtask
  task automatic do_reset();
    bus.tick = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_a = '0;
    bus.cfg_b = '0;
    bus.cfg_i = '0;
    bus.spk_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic cfg_write(input int k, input logic [3:0] a, input logic [3:0] b, input logic [7:0] i);
    bus.cfg_we = 1'b1;
    bus.cfg_idx = IW'(k);
    bus.cfg_a = a;
    bus.cfg_b = b;
    bus.cfg_i = i;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    a_m[k] = a;
    b_m[k] = b;
    i_m[k] = i;
  endtask
  task automatic run_tick(output bit first_start, output int bcyc);
    base = calls;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    first_start = bus.eng_start;
    bcyc = 0;
    while (bus.busy === 1'b1 && bcyc < 2000) begin
      bcyc++;
      @(negedge clk);
    end
    model_tick();
  endtask
  task automatic test_reset();
    bit fs;
    int bc;
    do_reset();
    lat_min = 2;
    lat_max = 2;
    spk_mask = '0;
    tests++;
    if (bus.busy !== 1'b0 || bus.overrun !== 1'b0 || bus.drop_cnt !== 8'd0 || bus.spk_valid !== 1'b0 ||
        bus.spk_idx !== '0 || bus.eng_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: busy=%b overrun=%b drop=%0d spk_valid=%b spk_idx=%0d eng_start=%b, required all 0",
               bus.busy, bus.overrun, bus.drop_cnt, bus.spk_valid, bus.spk_idx, bus.eng_start);
    end
    tests++;
    if ({bus.eng_v, bus.eng_u, bus.eng_a, bus.eng_b, bus.eng_i} !== '0) begin
      fails++;
      $display("FAIL reset_operands: v=%h u=%h a=%h b=%h i=%h, required 0",
               bus.eng_v, bus.eng_u, bus.eng_a, bus.eng_b, bus.eng_i);
    end
    for (int t = 0; t < 2; t++) begin
      run_tick(fs, bc);
      tests++;
      if (fs !== 1'b1) begin
        fails++;
        $display("FAIL tick_latency: eng_start one cycle after tick=%b, required 1", fs);
      end
      tests++;
      if (bc != exp_busy || bc != 16) begin
        fails++;
        $display("FAIL busy_cycles: got %0d, required %0d", bc, exp_busy);
      end
      for (int k = 0; k < N; k++) begin
        tests++;
        if (log_v[base + k] !== exp_v[k] || log_u[base + k] !== exp_u[k] || log_a[base + k] !== exp_a[k] ||
            log_b[base + k] !== exp_b[k] || log_i[base + k] !== exp_i[k]) begin
          fails++;
          $display("FAIL reset_tick_operands[%0d]: v=%h u=%h a=%h b=%h i=%h, required v=%h u=%h a=%h b=%h i=%h", k,
                   log_v[base + k], log_u[base + k], log_a[base + k], log_b[base + k], log_i[base + k],
                   exp_v[k], exp_u[k], exp_a[k], exp_b[k], exp_i[k]);
        end
      end
    end
  endtask
  task automatic test_cfg();
    bit fs;
    int bc;
    int n;
    int s;
    cfg_write(2, 4'd1, 4'd4, 8'h20);
    run_tick(fs, bc);
    for (int k = 0; k < N; k++) begin
      tests++;
      if (log_a[base + k] !== exp_a[k] || log_b[base + k] !== exp_b[k] || log_i[base + k] !== exp_i[k]) begin
        fails++;
        $display("FAIL cfg_operands[%0d]: a=%h b=%h i=%h, required a=%h b=%h i=%h", k,
                 log_a[base + k], log_b[base + k], log_i[base + k], exp_a[k], exp_b[k], exp_i[k]);
      end
    end
    tests++;
    if (log_a[base + 2] !== 4'd1 || log_b[base + 2] !== 4'd4 || log_i[base + 2] !== 8'h20) begin
      fails++;
      $display("FAIL cfg_idx2: a=%h b=%h i=%h, required a=1 b=4 i=20",
               log_a[base + 2], log_b[base + 2], log_i[base + 2]);
    end
    base = calls;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    n = 0;
    s = int'(bus.eng_start);
    while (s < 3 && n < 200) begin
      @(negedge clk);
      n++;
      s += int'(bus.eng_start);
    end
    bus.cfg_we = 1'b1;
    bus.cfg_idx = IW'(2);
    bus.cfg_a = 4'd7;
    bus.cfg_b = 4'd2;
    bus.cfg_i = 8'h55;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    tests++;
    if (s != 3 || bus.eng_a !== 4'd1 || bus.eng_b !== 4'd4 || bus.eng_i !== 8'h20) begin
      fails++;
      $display("FAIL cfg_inflight: starts=%0d a=%h b=%h i=%h, required starts=3 a=1 b=4 i=20",
               s, bus.eng_a, bus.eng_b, bus.eng_i);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL cfg_timestep_end: busy=%b, required 0", bus.busy);
    end
    model_tick();
    a_m[2] = 4'd7;
    b_m[2] = 4'd2;
    i_m[2] = 8'h55;
    run_tick(fs, bc);
    for (int k = 0; k < N; k++) begin
      tests++;
      if (log_v[base + k] !== exp_v[k] || log_a[base + k] !== exp_a[k] || log_b[base + k] !== exp_b[k] ||
          log_i[base + k] !== exp_i[k]) begin
        fails++;
        $display("FAIL cfg_next_tick[%0d]: v=%h a=%h b=%h i=%h, required v=%h a=%h b=%h i=%h", k,
                 log_v[base + k], log_a[base + k], log_b[base + k], log_i[base + k],
                 exp_v[k], exp_a[k], exp_b[k], exp_i[k]);
      end
    end
  endtask
  task automatic test_spike();
    bit fs;
    int bc;
    spk_mask = 4'b1010;
    run_tick(fs, bc);
    spk_mask = '0;
    while (fifo_m.size() > 0) begin
      tests++;
      if (bus.spk_valid !== 1'b1 || bus.spk_idx !== IW'(fifo_m[0])) begin
        fails++;
        $display("FAIL spike_head: valid=%b idx=%0d, required valid=1 idx=%0d", bus.spk_valid, bus.spk_idx, fifo_m[0]);
      end
      bus.spk_ready = 1'b1;
      @(negedge clk);
      bus.spk_ready = 1'b0;
      void'(fifo_m.pop_front());
    end
    tests++;
    if (bus.spk_valid !== 1'b0) begin
      fails++;
      $display("FAIL spike_empty: valid=%b, required 0", bus.spk_valid);
    end
    bus.spk_ready = 1'b1;
    @(negedge clk);
    bus.spk_ready = 1'b0;
    tests++;
    if (bus.spk_valid !== 1'b0 || bus.spk_idx !== '0 || bus.drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL empty_pop: valid=%b idx=%0d drop=%0d, required 0 0 0", bus.spk_valid, bus.spk_idx, bus.drop_cnt);
    end
  endtask
  task automatic test_fifo_full();
    bit fs;
    int bc;
    lat_min = 1;
    lat_max = 1;
    spk_mask = '1;
    run_tick(fs, bc);
    run_tick(fs, bc);
    tests++;
    if (bus.drop_cnt !== 8'(drop_m) || bus.drop_cnt !== 8'd4) begin
      fails++;
      $display("FAIL fifo_full_drops: drop=%0d, required %0d", bus.drop_cnt, drop_m);
    end
    repeat (66) run_tick(fs, bc);
    spk_mask = '0;
    tests++;
    if (bus.drop_cnt !== 8'(drop_m) || bus.drop_cnt !== 8'd255) begin
      fails++;
      $display("FAIL drop_saturate: drop=%0d, required %0d", bus.drop_cnt, drop_m);
    end
    while (fifo_m.size() > 0) begin
      tests++;
      if (bus.spk_valid !== 1'b1 || bus.spk_idx !== IW'(fifo_m[0])) begin
        fails++;
        $display("FAIL full_head: valid=%b idx=%0d, required valid=1 idx=%0d", bus.spk_valid, bus.spk_idx, fifo_m[0]);
      end
      bus.spk_ready = 1'b1;
      @(negedge clk);
      bus.spk_ready = 1'b0;
      void'(fifo_m.pop_front());
    end
    tests++;
    if (bus.spk_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_drained: valid=%b, required 0", bus.spk_valid);
    end
  endtask
  task automatic test_random();
    bit fs;
    int bc;
    do_reset();
    lat_min = 1;
    lat_max = 4;
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 2)) cfg_write(int'($urandom_range(0, N - 1)), 4'($urandom), 4'($urandom), 8'($urandom));
      spk_mask = N'($urandom);
      run_tick(fs, bc);
      tests++;
      if (fs !== 1'b1 || bc != exp_busy) begin
        fails++;
        $display("FAIL rand_timing[%0d]: first_start=%b busy=%0d, required 1 and %0d", t, fs, bc, exp_busy);
      end
      for (int k = 0; k < N; k++) begin
        tests++;
        if (log_v[base + k] !== exp_v[k] || log_u[base + k] !== exp_u[k] || log_a[base + k] !== exp_a[k] ||
            log_b[base + k] !== exp_b[k] || log_i[base + k] !== exp_i[k]) begin
          fails++;
          $display("FAIL rand_operands[%0d][%0d]: v=%h u=%h a=%h b=%h i=%h, required v=%h u=%h a=%h b=%h i=%h", t, k,
                   log_v[base + k], log_u[base + k], log_a[base + k], log_b[base + k], log_i[base + k],
                   exp_v[k], exp_u[k], exp_a[k], exp_b[k], exp_i[k]);
        end
      end
      tests++;
      if (bus.drop_cnt !== 8'(drop_m)) begin
        fails++;
        $display("FAIL rand_drop[%0d]: drop=%0d, required %0d", t, bus.drop_cnt, drop_m);
      end
      if ($urandom_range(0, 1) == 1 || t == 24) begin
        while (fifo_m.size() > 0) begin
          tests++;
          if (bus.spk_valid !== 1'b1 || bus.spk_idx !== IW'(fifo_m[0])) begin
            fails++;
            $display("FAIL rand_head[%0d]: valid=%b idx=%0d, required valid=1 idx=%0d", t, bus.spk_valid, bus.spk_idx, fifo_m[0]);
          end
          bus.spk_ready = 1'b1;
          @(negedge clk);
          bus.spk_ready = 1'b0;
          void'(fifo_m.pop_front());
        end
      end
    end
    tests++;
    if (bus.spk_valid !== 1'b0) begin
      fails++;
      $display("FAIL rand_drained: valid=%b, required 0", bus.spk_valid);
    end
  endtask
  task automatic test_overrun();
    int n0;
    int n;
    spk_mask = '0;
    lat_min = 2;
    lat_max = 2;
    n0 = nstart;
    base = calls;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    repeat (2) @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    tests++;
    if (bus.overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: overrun=%b, required 1", bus.overrun);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    tests++;
    if (nstart - n0 != N) begin
      fails++;
      $display("FAIL overrun_starts: eng_start pulses=%0d, required %0d", nstart - n0, N);
    end
    tests++;
    if (bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL overrun_sticky: overrun=%b busy=%b, required 1 0", bus.overrun, bus.busy);
    end
    model_tick();
  endtask
  task automatic test_reset_mid();
    bit fs;
    int bc;
    int n;
    int s;
    spk_mask = '1;
    lat_min = 2;
    lat_max = 2;
    base = calls;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    n = 0;
    s = int'(bus.eng_start);
    while (s < 3 && n < 200) begin
      @(negedge clk);
      n++;
      s += int'(bus.eng_start);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (s != 3 || bus.busy !== 1'b0 || bus.overrun !== 1'b0 || bus.eng_start !== 1'b0 || bus.spk_valid !== 1'b0 ||
        bus.eng_v !== '0) begin
      fails++;
      $display("FAIL reset_abort: starts=%0d busy=%b overrun=%b eng_start=%b spk_valid=%b eng_v=%h, required 3 0 0 0 0 0",
               s, bus.busy, bus.overrun, bus.eng_start, bus.spk_valid, bus.eng_v);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.spk_valid !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL late_done: busy=%b spk_valid=%b drop=%0d, required 0 0 0", bus.busy, bus.spk_valid, bus.drop_cnt);
    end
    spk_mask = '0;
    run_tick(fs, bc);
    for (int k = 0; k < N; k++) begin
      tests++;
      if (log_v[base + k] !== VI || log_u[base + k] !== UI || log_a[base + k] !== exp_a[k] ||
          log_b[base + k] !== exp_b[k] || log_i[base + k] !== exp_i[k]) begin
        fails++;
        $display("FAIL post_reset_state[%0d]: v=%h u=%h a=%h b=%h i=%h, required v=%h u=%h a=0 b=0 i=0", k,
                 log_v[base + k], log_u[base + k], log_a[base + k], log_b[base + k], log_i[base + k], VI, UI);
      end
    end
  endtask
  initial begin
    test_reset();
    test_cfg();
    test_spike();
    test_fifo_full();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
